// File: rtl/iram_loader_pkg.sv
// Shared definitions for the iRAM loader: default geometry and FSM state encodings.
package iram_loader_pkg;

    localparam int LDR_WORD_W = 32;
    localparam int LDR_ADDR_W = 10;
    localparam int LDR_LEN_W  = 16;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_LEN_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERR    = 3'd6
    } ldr_state_e;

endpackage

// File: rtl/iram_loader_if.sv
// Byte-stream valid/ready handshake feeding the iRAM loader.
interface iram_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/iram_loader_word_assembler.sv
// Collects bytes little-endian into one iRAM word; o_last flags the final byte slot.
module iram_loader_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_word;

    assign o_last = (r_idx == IDX_W'(NB - 1));
    assign o_word = r_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_word[8*r_idx +: 8] <= i_byte;
            r_idx                <= o_last ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Streams a length-prefixed program into iRAM and holds the CPU in reset until it is loaded.
//   state      | meaning
//   LDR_IDLE   | waiting for start after reset
//   LDR_LEN_LO | taking word-count low byte
//   LDR_LEN_HI | taking word-count high byte, judging the count
//   LDR_DATA   | assembling a word from the stream
//   LDR_WRITE  | one-cycle iRAM write of the assembled word
//   LDR_DONE   | program loaded, CPU released
//   LDR_ERR    | illegal count, CPU held in reset
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int WORD_W = LDR_WORD_W,
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int LEN_W  = LDR_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    iram_loader_if.slave      s_in,
    output logic              weI,
    output logic [WORD_W-1:0] dinI,
    output logic [ADDR_W-1:0] addrI,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam logic [LEN_W:0] MAX_CNT = (LEN_W + 1)'(1) << ADDR_W;

    ldr_state_e        r_state;
    ldr_state_e        w_next;
    logic [7:0]        r_len_lo;
    logic [LEN_W-1:0]  r_remaining;
    logic [ADDR_W-1:0] r_waddr;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_asm_clr;
    logic              w_asm_load;
    logic [LEN_W-1:0]  w_count;
    logic              w_too_big;

    assign w_accept      = s_in.in_valid && w_in_ready;
    assign s_in.in_ready = w_in_ready;
    assign w_count       = LEN_W'({s_in.in_data, r_len_lo});
    assign w_too_big     = ({1'b0, w_count} > MAX_CNT);
    assign w_asm_clr     = (r_state == LDR_WRITE) || (r_state == LDR_LEN_HI && w_accept);
    assign w_asm_load    = (r_state == LDR_DATA) && w_accept;
    assign addrI         = r_waddr;

    iram_loader_word_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_asm_clr),
        .i_load (w_asm_load),
        .i_byte (s_in.in_data),
        .o_word (dinI),
        .o_last (w_last)
    );

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        weI        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst_n  = 1'b0;
        case (r_state)
            LDR_IDLE: begin
                if (start) w_next = LDR_LEN_LO;
            end
            LDR_LEN_LO: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) w_next = LDR_LEN_HI;
            end
            LDR_LEN_HI: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) begin
                    if (w_count == '0)  w_next = LDR_DONE;
                    else if (w_too_big) w_next = LDR_ERR;
                    else                w_next = LDR_DATA;
                end
            end
            LDR_DATA: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && w_last) w_next = LDR_WRITE;
            end
            LDR_WRITE: begin
                weI    = 1'b1;
                busy   = 1'b1;
                w_next = (r_remaining == LEN_W'(1)) ? LDR_DONE : LDR_DATA;
            end
            LDR_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) w_next = LDR_LEN_LO;
            end
            LDR_ERR: begin
                err = 1'b1;
                if (start) w_next = LDR_LEN_LO;
            end
            default: w_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= LDR_IDLE;
            r_len_lo    <= '0;
            r_remaining <= '0;
            r_waddr     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LDR_LEN_LO && w_accept) r_len_lo <= s_in.in_data;
            if (r_state == LDR_LEN_HI && w_accept && w_next == LDR_DATA) begin
                r_remaining <= w_count;
                r_waddr     <= '0;
            end
            // Address holds on the final word so a full-depth load never wraps to 0.
            if (r_state == LDR_WRITE) begin
                r_remaining <= r_remaining - LEN_W'(1);
                if (r_remaining != LEN_W'(1)) r_waddr <= r_waddr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: header/data streaming, gaps, errors, reset and full depth.
module tb_iram_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        weI;
    logic [31:0] dinI;
    logic [9:0]  addrI;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    iram_loader_if u_if ();

    iram_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_in      (u_if.slave),
        .weI       (weI),
        .dinI      (dinI),
        .addrI     (addrI),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    int          checks;
    int          failures;
    int          wr_cnt;
    logic [9:0]  last_addr;
    logic [31:0] last_data;
    logic [31:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (weI) begin
            mem[addrI] = dinI;
            wr_cnt     = wr_cnt + 1;
            last_addr  = addrI;
            last_data  = dinI;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a byte after `gap` idle cycles and return once the edge accepting it has passed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            u_if.in_valid = 1'b0;
            tick();
        end
        u_if.in_valid = 1'b1;
        u_if.in_data  = b;
        n = 0;
        while (!u_if.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("ready_timeout", {31'd0, u_if.in_ready}, 32'd1);
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 0);
        send_byte(w[15:8], 0);
        send_byte(w[23:16], 0);
        send_byte(w[31:24], 0);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!done && !err && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("end_timeout", {31'd0, done | err}, 32'd1);
    endtask

    initial begin
        int base;
        logic [31:0] kv;
        checks        = 0;
        failures      = 0;
        wr_cnt        = 0;
        last_addr     = '0;
        last_data     = '0;
        rst           = 1'b0;
        start         = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;

        // Reset values
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd0);
        chk("rst_weI",      {31'd0, weI},           32'd0);
        chk("rst_dinI",     dinI,                   32'd0);
        chk("rst_addrI",    {22'd0, addrI},         32'd0);
        chk("rst_busy_done_err_cpu", {28'd0, busy, done, err, cpu_rst_n}, 32'd0);
        rst = 1'b1;
        tick();

        // Basic load: two words
        pulse_start();
        chk("basic_lenlo_busy_ready", {30'd0, busy, u_if.in_ready}, 32'd3);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h1234_5678);
        chk("basic_w0_weI",   {31'd0, weI},   32'd1);
        chk("basic_w0_addr",  {22'd0, addrI}, 32'd0);
        chk("basic_w0_data",  dinI,           32'h1234_5678);
        chk("basic_w0_ready", {31'd0, u_if.in_ready}, 32'd0);
        send_word(32'hDEAD_BEEF);
        chk("basic_w1_weI",   {31'd0, weI},   32'd1);
        chk("basic_w1_addr",  {22'd0, addrI}, 32'd1);
        chk("basic_w1_data",  dinI,           32'hDEAD_BEEF);
        tick();
        chk("basic_done_cpu_busy", {29'd0, done, cpu_rst_n, busy}, 32'd6);
        chk("basic_wr_cnt", wr_cnt, 32'd2);
        chk("basic_mem0", mem[0], 32'h1234_5678);
        chk("basic_mem1", mem[1], 32'hDEAD_BEEF);

        // in_valid held in DONE is not consumed
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h55;
        repeat (3) tick();
        chk("done_hold_ready", {31'd0, u_if.in_ready}, 32'd0);
        chk("done_hold_done",  {31'd0, done},          32'd1);
        u_if.in_valid = 1'b0;

        // Zero count
        base = wr_cnt;
        pulse_start();
        chk("zero_restart_done_cpu", {30'd0, done, cpu_rst_n}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        u_if.in_valid = 1'b0;
        chk("zero_done_cpu_busy", {29'd0, done, cpu_rst_n, busy}, 32'd6);
        chk("zero_no_write", wr_cnt - base, 32'd0);

        // Illegal count 1025
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        chk("err_flags", {28'd0, err, done, cpu_rst_n, u_if.in_ready}, 32'd8);
        repeat (3) tick();
        chk("err_held", {31'd0, err}, 32'd1);
        chk("err_no_write", wr_cnt - base, 32'd0);
        u_if.in_valid = 1'b0;
        pulse_start();
        chk("err_restart", {29'd0, err, busy, u_if.in_ready}, 32'd3);

        // Gaps, start ignored mid-load, count=1
        base = wr_cnt;
        send_byte(8'h01, 2);
        send_byte(8'h00, 1);
        send_byte(8'h11, 3);
        send_byte(8'h22, 0);
        u_if.in_valid = 1'b0;
        pulse_start();
        send_byte(8'h33, 2);
        send_byte(8'h44, 1);
        u_if.in_valid = 1'b0;
        chk("gap_weI",  {31'd0, weI},   32'd1);
        chk("gap_data", dinI,           32'h4433_2211);
        wait_end(20);
        chk("gap_wr_cnt", wr_cnt - base, 32'd1);
        chk("gap_mem0",   mem[0],        32'h4433_2211);
        chk("gap_done",   {31'd0, done}, 32'd1);

        // Reset mid-word
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b0;
        tick();
        u_if.in_valid = 1'b0;
        chk("mid_rst_flags", {26'd0, u_if.in_ready, weI, busy, done, err, cpu_rst_n}, 32'd0);
        chk("mid_rst_dinI",  dinI,           32'd0);
        chk("mid_rst_addrI", {22'd0, addrI}, 32'd0);
        rst = 1'b1;
        tick();
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDDCC_BBAA);
        u_if.in_valid = 1'b0;
        chk("restart_data", dinI, 32'hDDCC_BBAA);
        wait_end(20);
        chk("restart_mem0",   mem[0],        32'hDDCC_BBAA);
        chk("restart_wr_cnt", wr_cnt - base, 32'd1);

        // Full depth: 1024 words, word k = k
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int k = 0; k < 1024; k++) begin
            kv = k;
            send_word(kv);
        end
        u_if.in_valid = 1'b0;
        wait_end(20);
        repeat (4) tick();
        chk("full_wr_cnt",    wr_cnt - base,      32'd1024);
        chk("full_last_addr", {22'd0, last_addr}, 32'd1023);
        chk("full_last_data", last_data,          32'd1023);
        chk("full_mem0",      mem[0],             32'd0);
        chk("full_mem513",    mem[513],           32'd513);
        chk("full_done_cpu",  {30'd0, done, cpu_rst_n}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
